hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard/stall controller for the in-order pipeline. It replaces fixed-depth compare logic with a shift-register scoreboard of in-flight register writes. It adds a forwarding-aware mode (stall on load-use only), counter-based branch/jump flush windows, a pending-write bitmask and a saturating stall counter. It sits beside the decode stage and drives stall/flush to the IF/ID and ID/EX pipeline registers.

Parameters:
REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W
PIPE_DEPTH, 3, in-flight slots past decode (slot0=ID/EX … slot PIPE_DEPTH-1=MEM/WB); ≥2
FWD_EN, 0, 0: stall until writer leaves last slot; 1: stall only when slot0 holds a load
BR_SLOT, 1, slot holding a resolving branch; slots < BR_SLOT are squashed on taken
JUMP_FLUSH_CYCLES, 2, flush length for a jump seen in ID/EX; ≥1
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_valid  in  1  valid instruction in IF/ID
id_rs1_en  in  1  rs1 is read
id_rs1_addr  in  REG_ADDR_W  rs1 address
id_rs2_en  in  1  rs2 is read
id_rs2_addr  in  REG_ADDR_W  rs2 address
id_wr_en  in  1  instruction writes a register
id_wr_addr  in  REG_ADDR_W  destination address
id_is_load  in  1  instruction is a load
branch_taken  in  1  taken branch resolved in slot BR_SLOT
jump_idex  in  1  jump occupies ID/EX
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
flush  out  1  squash IF/ID and slots < BR_SLOT
inflight_mask  out  NUM_REGS  bit r set if any valid slot writes r
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot k = {valid, addr, is_load}. Every cycle slots shift k→k+1. Slot PIPE_DEPTH-1 retires.
- Slot0 next value: {id_valid & id_wr_en, id_wr_addr, id_is_load} when issue = id_valid & ~stall & ~flush. Otherwise slot0 becomes a bubble (valid=0).
- Source match: src_en & id_valid & addr equal to a valid slot's addr.
- FWD_EN=0: stall_raw = match against any slot 0..PIPE_DEPTH-1. Register file has no write-through, so a writer in the last slot still stalls.
- FWD_EN=1: stall_raw = match against slot0 with is_load=1.
- stall = stall_raw & ~flush (combinational). Flush always wins over stall.
- flush = branch_taken | jump_idex | (fcnt != 0) (combinational).
- fcnt (flush counter), registered:
  - on jump_idex, load max(fcnt-1, JUMP_FLUSH_CYCLES-1);
  - on branch_taken, load max(fcnt-1, 0);
  - otherwise decrement toward 0.
  - A simultaneous branch and jump uses the larger value.
- On branch_taken, at the clock edge: slots < BR_SLOT are cleared after the shift, slot-for-slot, covering the instructions younger than the branch. Slots ≥ BR_SLOT shift normally.
- inflight_mask is the OR-decode of valid slots, registered view (same cycle as slots).
- stall_count increments on each cycle stall=1 and saturates at 2**CNT_W-1.
- Reset (rst=0, asynchronous):
  - all slots invalid, fcnt=0, stall_count=0;
  - hence stall=0, flush=0, inflight_mask=0.
  - Reset mid-stall or mid-flush drops everything immediately; no pending writes survive.
- Latency: stall and flush respond in the same cycle as their inputs. The scoreboard updates at the next edge.
- Writes to any register, including r0, are tracked; no hardwired-zero exemption.

Test Plan:
- Defaults (FWD_EN=0, PIPE_DEPTH=3): issue wr r3, next cycle reader rs1=3 → stall=1 for exactly 3 cycles, then reader issues; stall_count=3; inflight_mask bit3 high 3 cycles.
- FWD_EN=1: load to r5, next reader rs2=5 → stall 1 cycle. ALU write r5 then reader → stall 0.
- Reader stalled on r2 writer in slot0, branch_taken=1 → stall=0, flush=1 that cycle. Next cycle slot0 cleared; r2 bit drops unless the writer was at/after BR_SLOT; flush=0 the following cycle.
- jump_idex pulse → flush high 2 cycles. branch_taken in 2nd cycle → flush high exactly 2 cycles total, no extension.
- rst asserted during a 3-cycle stall → stall, flush, inflight_mask, stall_count all 0 without a clock edge. After release, a reader of the prior register does not stall.
- CNT_W=2, continuous dependency chain stalling 6 cycles → stall_count sequence 1,2,3,3,3,3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift-register scoreboard driving pipeline stall/flush
module hazard_scoreboard #(
  parameter int REG_ADDR_W        = 3,
  parameter int PIPE_DEPTH        = 3,
  parameter int FWD_EN            = 0,
  parameter int BR_SLOT           = 1,
  parameter int JUMP_FLUSH_CYCLES = 2,
  parameter int CNT_W             = 16,
  localparam int NUM_REGS         = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_rs1_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  input  logic                  jump_idex,
  output logic                  stall,
  output logic                  flush,
  output logic [NUM_REGS-1:0]   inflight_mask,
  output logic [CNT_W-1:0]      stall_count
);

  // Flush counter only ever holds values up to JUMP_FLUSH_CYCLES-1.
  localparam int FCNT_W = (JUMP_FLUSH_CYCLES > 1) ? $clog2(JUMP_FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] JUMP_LOAD = FCNT_W'(JUMP_FLUSH_CYCLES - 1);

  logic [PIPE_DEPTH-1:0] slotValid;
  logic [PIPE_DEPTH-1:0] slotLoad;
  logic [REG_ADDR_W-1:0] slotAddr [PIPE_DEPTH];

  logic [FCNT_W-1:0]     fcnt;
  logic [FCNT_W-1:0]     fcntDec;
  logic [FCNT_W-1:0]     fcntNext;
  logic [PIPE_DEPTH-1:0] srcHit;
  logic                  stallRaw;
  logic                  issue;

  // Per-slot source match: either enabled source reads the slot's destination.
  always_comb begin
    srcHit = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      srcHit[k] = id_valid && slotValid[k] &&
                  ((id_rs1_en && (slotAddr[k] == id_rs1_addr)) ||
                   (id_rs2_en && (slotAddr[k] == id_rs2_addr)));
    end
  end

  // Without forwarding any in-flight writer blocks the reader (no write-through in the
  // register file); with forwarding only a load still sitting in ID/EX does.
  always_comb begin
    if (FWD_EN != 0) begin
      stallRaw = srcHit[0] & slotLoad[0];
    end else begin
      stallRaw = |srcHit;
    end
    flush = branch_taken | jump_idex | (fcnt != '0);
    stall = stallRaw & ~flush;
    issue = id_valid & ~stall & ~flush;
  end

  // Flush window: decrement toward zero, a jump reloads to at least its full window.
  always_comb begin
    fcntDec  = (fcnt != '0) ? (fcnt - FCNT_W'(1)) : '0;
    fcntNext = fcntDec;
    if (jump_idex && (JUMP_LOAD > fcntDec)) begin
      fcntNext = JUMP_LOAD;
    end
  end

  // Flush counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcntNext;
    end
  end

  // Scoreboard shift. On a taken branch the instructions younger than the branch
  // (those that were in slots below BR_SLOT) are dropped as they shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotValid <= '0;
      slotLoad  <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slotAddr[k] <= '0;
      end
    end else begin
      slotValid[0] <= issue & id_wr_en;
      slotAddr[0]  <= id_wr_addr;
      slotLoad[0]  <= id_is_load;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        slotValid[k] <= slotValid[k-1] & ~(branch_taken && (k <= BR_SLOT));
        slotAddr[k]  <= slotAddr[k-1];
        slotLoad[k]  <= slotLoad[k-1];
      end
    end
  end

  // Pending-write bitmask decoded from the valid slots.
  always_comb begin
    inflight_mask = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (slotValid[k]) begin
        inflight_mask[slotAddr[k]] = 1'b1;
      end
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks against an age-list model
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int BRS   = 1;
  localparam int JFC   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_rs1_en = 1'b0;
  logic [2:0] id_rs1_addr = '0;
  logic       id_rs2_en = 1'b0;
  logic [2:0] id_rs2_addr = '0;
  logic       id_wr_en = 1'b0;
  logic [2:0] id_wr_addr = '0;
  logic       id_is_load = 1'b0;
  logic       branch_taken = 1'b0;
  logic       jump_idex = 1'b0;

  logic        stallO [3];
  logic        flushO [3];
  logic [7:0]  maskO  [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_scoreboard u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .jump_idex(jump_idex),
    .stall(stallO[0]), .flush(flushO[0]), .inflight_mask(maskO[0]), .stall_count(cnt0)
  );

  hazard_scoreboard #(.FWD_EN(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .jump_idex(jump_idex),
    .stall(stallO[1]), .flush(flushO[1]), .inflight_mask(maskO[1]), .stall_count(cnt1)
  );

  hazard_scoreboard #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .jump_idex(jump_idex),
    .stall(stallO[2]), .flush(flushO[2]), .inflight_mask(maskO[2]), .stall_count(cnt2)
  );

  // Reference model: each instance keeps a list of in-flight writes tagged with their age.
  int fwdCfg [3] = '{0, 1, 0};
  int cntMax [3] = '{65535, 65535, 3};
  bit mV   [3][8];
  int mA   [3][8];
  bit mL   [3][8];
  int mAge [3][8];
  int mLeft [3];
  int mCnt  [3];
  bit expStall [3];
  bit expFlush [3];
  logic [7:0] expMask [3];

  int passCount = 0;
  int totalCount = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      for (int e = 0; e < 8; e++) mV[i][e] = 1'b0;
      mLeft[i] = 0;
      mCnt[i]  = 0;
    end
  endtask

  task automatic modelEval(input int i);
    bit raw;
    bit hit;
    logic [7:0] m;
    raw = 1'b0;
    m = '0;
    for (int e = 0; e < 8; e++) begin
      if (mV[i][e]) begin
        m[mA[i][e]] = 1'b1;
        hit = id_valid && ((id_rs1_en && mA[i][e] == int'(id_rs1_addr)) ||
                           (id_rs2_en && mA[i][e] == int'(id_rs2_addr)));
        if (fwdCfg[i] == 0) begin
          if (hit) raw = 1'b1;
        end else if (hit && mAge[i][e] == 0 && mL[i][e]) begin
          raw = 1'b1;
        end
      end
    end
    expFlush[i] = branch_taken || jump_idex || (mLeft[i] > 0);
    expStall[i] = raw && !expFlush[i];
    expMask[i]  = m;
  endtask

  task automatic modelStep(input int i);
    int nl;
    bit placed;
    if (!rst) begin
      for (int e = 0; e < 8; e++) mV[i][e] = 1'b0;
      mLeft[i] = 0;
      mCnt[i]  = 0;
      return;
    end
    if (expStall[i] && mCnt[i] < cntMax[i]) mCnt[i]++;
    nl = (mLeft[i] > 0) ? mLeft[i] - 1 : 0;
    if (jump_idex && (JFC - 1) > nl) nl = JFC - 1;
    mLeft[i] = nl;
    for (int e = 0; e < 8; e++) begin
      if (mV[i][e]) begin
        if (branch_taken && mAge[i][e] < BRS) begin
          mV[i][e] = 1'b0;
        end else begin
          mAge[i][e]++;
          if (mAge[i][e] >= DEPTH) mV[i][e] = 1'b0;
        end
      end
    end
    if (id_valid && !expStall[i] && !expFlush[i] && id_wr_en) begin
      placed = 1'b0;
      for (int e = 0; e < 8; e++) begin
        if (!placed && !mV[i][e]) begin
          mV[i][e] = 1'b1; mA[i][e] = int'(id_wr_addr);
          mL[i][e] = id_is_load; mAge[i][e] = 0;
          placed = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      modelEval(i);
      chk($sformatf("stall[%0d]", i), 32'(stallO[i]), 32'(expStall[i]));
      chk($sformatf("flush[%0d]", i), 32'(flushO[i]), 32'(expFlush[i]));
      chk($sformatf("mask[%0d]", i), 32'(maskO[i]), 32'(expMask[i]));
    end
    chk("count[0]", 32'(cnt0), 32'(mCnt[0]));
    chk("count[1]", 32'(cnt1), 32'(mCnt[1]));
    chk("count[2]", 32'(cnt2), 32'(mCnt[2]));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    #1;
  endtask

  task automatic setInst(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                         input bit we, input int wa, input bit ld);
    id_valid = v; id_rs1_en = r1e; id_rs1_addr = 3'(r1);
    id_rs2_en = r2e; id_rs2_addr = 3'(r2);
    id_wr_en = we; id_wr_addr = 3'(wa); id_is_load = ld;
    branch_taken = 1'b0; jump_idex = 1'b0;
  endtask

  task automatic idle(input int n);
    setInst(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int c1Before;

  initial begin
    modelReset();
    // Reset state
    idle(2);
    rst = 1'b1;
    idle(1);

    // Write r3, then a reader of r3 held until it issues
    setInst(1, 0, 0, 0, 0, 1, 3, 0); cycle();
    setInst(1, 1, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    chk("dep_stall_count", 32'(cnt0), 32'd3);
    idle(3);

    // Forwarding: load-use stalls one cycle, ALU-use does not
    c1Before = int'(cnt1);
    setInst(1, 0, 0, 0, 0, 1, 5, 1); cycle();
    setInst(1, 0, 0, 1, 5, 0, 0, 0); cycle(); cycle();
    chk("fwd_load_use", 32'(cnt1), 32'(c1Before + 1));
    idle(3);
    setInst(1, 0, 0, 0, 0, 1, 5, 0); cycle();
    setInst(1, 0, 0, 1, 5, 0, 0, 0); cycle();
    chk("fwd_alu_use", 32'(cnt1), 32'(c1Before + 1));
    idle(3);

    // Branch while a reader waits on the r2 writer in ID/EX
    setInst(1, 0, 0, 0, 0, 1, 2, 0); cycle();
    setInst(1, 1, 2, 0, 0, 0, 0, 0); branch_taken = 1'b1;
    #1;
    chk("br_stall", 32'(stallO[0]), 32'd0);
    chk("br_flush", 32'(flushO[0]), 32'd1);
    cycle();
    setInst(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_mask_r2", 32'(maskO[0][2]), 32'd0);
    chk("br_flush_after", 32'(flushO[0]), 32'd0);
    idle(3);

    // Jump window, then jump followed by branch in its second cycle
    setInst(0, 0, 0, 0, 0, 0, 0, 0); jump_idex = 1'b1; cycle();
    idle(2);
    setInst(0, 0, 0, 0, 0, 0, 0, 0); jump_idex = 1'b1; cycle();
    setInst(0, 0, 0, 0, 0, 0, 0, 0); branch_taken = 1'b1; cycle();
    setInst(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("jmp_br_no_ext", 32'(flushO[0]), 32'd0);
    idle(2);

    // Asynchronous reset in the middle of a stall
    setInst(1, 0, 0, 0, 0, 1, 4, 0); cycle();
    setInst(1, 1, 4, 0, 0, 0, 0, 0); cycle();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    chk("rst_stall", 32'(stallO[0]), 32'd0);
    chk("rst_flush", 32'(flushO[0]), 32'd0);
    chk("rst_mask", 32'(maskO[0]), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    cycle();
    rst = 1'b1;
    setInst(1, 1, 4, 0, 0, 0, 0, 0); cycle();
    idle(3);

    // Continuous dependency chain on r1: six stall cycles saturate the 2-bit counter
    setInst(1, 1, 1, 0, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) cycle();
    chk("chain_sat_count", 32'(cnt2), 32'd3);
    chk("chain_full_count", 32'(cnt0), 32'd6);
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      setInst(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), $urandom_range(0, 7),
              bit'($urandom_range(0, 1)), $urandom_range(0, 7), bit'($urandom_range(0, 1)),
              $urandom_range(0, 7), bit'($urandom_range(0, 2) == 0));
      branch_taken = ($urandom_range(0, 9) == 0);
      jump_idex = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) != 0);
      if (!rst) begin
        setInst(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        modelReset();
      end
      cycle();
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
